// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES constants, FSM encoding and S-box lookup tables.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int c_num_bytes = 16;
    localparam int c_state_w   = 128;

    // Byte 0 of the AES state is the most significant byte (index 15).
    typedef logic [c_num_bytes-1:0][7:0] state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } sb_state_e;

    // Tables are listed from entry 0 downward, so entry b sits at index ~b.
    localparam logic [255:0][7:0] c_sbox_fwd = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [255:0][7:0] c_sbox_inv = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        return c_sbox_fwd[~b];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        return c_sbox_inv[~b];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sbox.sv
`default_nettype none
// ============================================================================
// Module      : sbox
// Description : Combinational AES forward S-box, one byte.
// Revision    : 1.0 - initial release
// ============================================================================
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = sbox_fwd(i_byte);

endmodule
`default_nettype wire

// File: rtl/sub_bytes_iter.sv
`default_nettype none
// ============================================================================
// Module      : sub_bytes_iter
// Description : Iterative AES SubBytes, BYTES_PER_CYCLE bytes per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [c_state_w-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [c_state_w-1:0] out_data
);

    localparam int NUM_STEPS = c_num_bytes / BYTES_PER_CYCLE;
    localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    sb_state_e          r_state;
    sb_state_e          w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    state_t             r_work;
    state_t             w_work_next;
    logic               w_last;
    logic [3:0]         w_pos    [BYTES_PER_CYCLE];
    logic [7:0]         w_sb_in  [BYTES_PER_CYCLE];
    logic [7:0]         w_sb_out [BYTES_PER_CYCLE];

    assign w_last = (r_cnt == CNT_W'(NUM_STEPS - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_next = ST_BUSY;
            ST_BUSY: if (w_last)    w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Step k covers bytes k*BPC .. k*BPC+BPC-1, byte 0 being the top byte.
    always_comb begin
        for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
            w_pos[g]   = 4'(c_num_bytes - 1 - int'(r_cnt) * BYTES_PER_CYCLE - g);
            w_sb_in[g] = r_work[w_pos[g]];
        end
    end

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
        sbox u_sbox (
            .i_byte (w_sb_in[g]),
            .o_byte (w_sb_out[g])
        );
    end

    always_comb begin
        w_work_next = r_work;
        for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
            w_work_next[w_pos[g]] = w_sb_out[g];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_work <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_work <= in_data;
                        r_cnt  <= '0;
                    end
                end
                ST_BUSY: begin
                    r_work <= w_work_next;
                    r_cnt  <= w_last ? '0 : r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_data  = out_valid ? r_work : '0;

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_bytes_iter
// Description : Self-checking bench for sub_bytes_iter across all BPC values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_bytes_iter;

    localparam int N_INST = 5;   // instance j uses BYTES_PER_CYCLE = 1 << j

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid  [N_INST];
    logic         in_ready  [N_INST];
    logic [127:0] in_data   [N_INST];
    logic         out_valid [N_INST];
    logic         out_ready [N_INST];
    logic [127:0] out_data  [N_INST];

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_fwd [256];
    logic [7:0] m_inv [256];

    always #5 clk = ~clk;

    for (genvar i = 0; i < N_INST; i++) begin : g_dut
        sub_bytes_iter #(.BYTES_PER_CYCLE(1 << i)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid[i]),
            .in_ready  (in_ready[i]),
            .in_data   (in_data[i]),
            .out_valid (out_valid[i]),
            .out_ready (out_ready[i]),
            .out_data  (out_data[i])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference S-box built from GF(2^8) inversion followed by the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = m_fwd[s[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] ref_inv_sub(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = m_inv[s[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input int j, input logic [127:0] d);
        int k = 0;
        while (!in_ready[j] && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (k == 50) check("in_ready_timeout", 128'd0, 128'd1);
        in_valid[j] = 1'b1;
        in_data[j]  = d;
        @(posedge clk); #1;
        in_valid[j] = 1'b0;
        in_data[j]  = rand128();
    endtask

    // Edges counted from the accepting handshake until out_valid is seen.
    task automatic wait_out(input int j, output int lat);
        lat = 0;
        while (!out_valid[j] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take(input int j);
        out_ready[j] = 1'b1;
        @(posedge clk); #1;
        out_ready[j] = 1'b0;
    endtask

    task automatic run_vec(input int j, input string tag, input logic [127:0] d,
                           input logic [127:0] exp, input int exp_lat);
        int lat;
        send(j, d);
        wait_out(j, lat);
        check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        check({tag, "_data"}, out_data[j], exp);
        check({tag, "_model"}, out_data[j], ref_sub(d));
        take(j);
        check({tag, "_ready_after"}, {127'd0, in_ready[j]}, 128'd1);
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] held;
        int lat;
        int j;
        int k;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            m_fwd[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) m_inv[m_fwd[x]] = 8'(x);

        reset = 1'b1;
        for (int i = 0; i < N_INST; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            out_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < N_INST; i++) begin
            check($sformatf("rst_out_valid%0d", i), {127'd0, out_valid[i]}, 128'd0);
            check($sformatf("rst_in_ready%0d", i),  {127'd0, in_ready[i]},  128'd1);
            check($sformatf("rst_out_data%0d", i),  out_data[i],            128'd0);
        end

        run_vec(2, "known", 128'hbdb52189f261b63d0b107c9e8b6e776e,
                128'h7ad5fda789ef4e272bca100b3d9ff59f, 4);
        run_vec(2, "zeros", 128'h0, {16{8'h63}}, 4);
        run_vec(2, "ones",  {16{8'hff}}, {16{8'h16}}, 4);

        for (int i = 0; i < N_INST; i++)
            run_vec(i, $sformatf("sweep_bpc%0d", 1 << i), {16{8'h53}}, {16{8'hed}}, 16 >> i);

        // Backpressure: held result, stray in_valid pulses must be ignored.
        d = rand128();
        send(2, d);
        wait_out(2, lat);
        held = out_data[2];
        check("bp_first", held, ref_sub(d));
        for (int c = 0; c < 10; c++) begin
            in_valid[2] = c[0];
            in_data[2]  = rand128();
            @(posedge clk); #1;
            check("bp_valid", {127'd0, out_valid[2]}, 128'd1);
            check("bp_ready", {127'd0, in_ready[2]},  128'd0);
            check("bp_data",  out_data[2], held);
        end
        in_valid[2] = 1'b0;
        take(2);
        check("bp_release_ready", {127'd0, in_ready[2]},  128'd1);
        check("bp_release_valid", {127'd0, out_valid[2]}, 128'd0);

        // Reset after two BUSY steps.
        send(2, rand128());
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_valid", {127'd0, out_valid[2]}, 128'd0);
        check("midrst_ready", {127'd0, in_ready[2]},  128'd1);
        check("midrst_data",  out_data[2],            128'd0);
        d = rand128();
        run_vec(2, "post_rst", d, ref_sub(d), 4);

        // Random stream across all widths with random downstream readiness.
        for (int t = 0; t < 100; t++) begin
            j = $urandom_range(0, N_INST - 1);
            d = rand128();
            send(j, d);
            k = 0;
            while (k < 200) begin
                out_ready[j] = 1'($urandom_range(0, 1));
                if (out_valid[j] && out_ready[j]) begin
                    check("stream_data", out_data[j], ref_sub(d));
                    check("stream_inv",  ref_inv_sub(out_data[j]), d);
                    @(posedge clk); #1;
                    out_ready[j] = 1'b0;
                    break;
                end
                @(posedge clk); #1;
                k++;
            end
            out_ready[j] = 1'b0;
            if (k == 200) check("stream_timeout", 128'd0, 128'd1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
